// File: rtl/pipe_sequencer.sv
// In-order pipeline sequencer: per-stage valid/data registers with back-pressure,
// younger-stage flush and retire/bubble performance counters.
module pipe_sequencer #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall_req,
    input  logic [STAGES-1:0]         flush_req,
    input  logic                      out_ready,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      cnt_clear,
    output logic [CNT_W-1:0]          retire_count,
    output logic [CNT_W-1:0]          bubble_count
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] hold, kill, advance;
    logic [CNT_W-1:0]  retire_q, retire_d, bubble_q, bubble_d;
    logic              accept;
    logic              unused_flush0;

    assign unused_flush0 = flush_req[0];

    // Hold ripples down from the oldest stage; kill is a suffix-OR of older flush requests.
    always_comb begin
        hold = '0;
        kill = '0;
        hold[STAGES-1] = valid_q[STAGES-1] & (stall_req[STAGES-1] | ~out_ready);
        for (int unsigned i = 1; i < STAGES; i++) begin
            hold[STAGES-1-i] = valid_q[STAGES-1-i] & (stall_req[STAGES-1-i] | hold[STAGES-i]);
            kill[STAGES-1-i] = kill[STAGES-i] | flush_req[STAGES-i];
        end
    end

    assign advance  = valid_q & ~hold & ~kill;
    assign in_ready = ~reset & ~hold[0] & ~kill[0];
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            data_d[k] = '0;
            if (!kill[k]) begin
                if (hold[k]) begin
                    valid_d[k] = valid_q[k];
                    data_d[k]  = data_q[k];
                end else if (k == 0) begin
                    valid_d[k] = accept;
                    data_d[k]  = accept ? in_data : '0;
                end else if (advance[k-1]) begin
                    valid_d[k] = 1'b1;
                    data_d[k]  = data_q[k-1];
                end
            end
        end
    end

    always_comb begin
        retire_d = retire_q;
        bubble_d = bubble_q;
        if (cnt_clear) begin
            retire_d = '0;
            bubble_d = '0;
        end else begin
            if (out_valid && out_ready) retire_d = retire_q + CNT_W'(1);
            if (!out_valid)             bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= '0;
            data_q   <= '{default: '0};
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    always_comb begin
        stage_data = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stage_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign stage_valid  = valid_q;
    assign out_valid    = valid_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign retire_count = retire_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer (4 stages, 16-bit payload, 4-bit counters).
module tb_pipe_sequencer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  stall_req;
    logic [3:0]  flush_req;
    logic        out_ready;
    logic [3:0]  stage_valid;
    logic [63:0] stage_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        cnt_clear;
    logic [3:0]  retire_count;
    logic [3:0]  bubble_count;

    int checks = 0;
    int errors = 0;

    pipe_sequencer #(.STAGES(4), .WIDTH(16), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall_req    (stall_req),
        .flush_req    (flush_req),
        .out_ready    (out_ready),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .cnt_clear    (cnt_clear),
        .retire_count (retire_count),
        .bubble_count (bubble_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; stall_req = '0; flush_req = '0;
        out_ready = 1'b1; cnt_clear = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 0);
        tick(); tick();
        chk("reset_valid", stage_valid, 0);
        chk("reset_data", stage_data, 0);
        chk("reset_retire", retire_count, 0);
        chk("reset_bubble", bubble_count, 0);

        // Back-to-back stream 1..6, 4-edge latency
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            in_valid = (c <= 6);
            in_data  = (c <= 6) ? 16'(c) : 16'h0;
            #1;
            if (c <= 6) chk("p1_in_ready", in_ready, 1);
            tick();
            chk("p1_out_valid", out_valid, (c >= 4 && c <= 9) ? 1 : 0);
            chk("p1_out_data", out_data, (c >= 4 && c <= 9) ? 64'(c - 3) : 64'h0);
        end
        chk("p1_retire", retire_count, 6);
        chk("p1_bubble", bubble_count, 6);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("clr_retire", retire_count, 0);
        chk("clr_bubble", bubble_count, 0);

        // Fill, then stall stage 2 for two cycles
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h11 + i);
            tick();
        end
        chk("p2_fill_valid", stage_valid, 4'hF);
        chk("p2_fill_data", stage_data, 64'h0011_0012_0013_0014);
        in_valid = 1'b0;
        #1;
        chk("p2_full_in_ready", in_ready, 0);
        tick();
        chk("p2_full_valid", stage_valid, 4'hF);
        out_ready = 1'b1; stall_req = 4'b0100; in_valid = 1'b1; in_data = 16'h15;
        #1;
        chk("p2_stallA_in_ready", in_ready, 0);
        tick();
        chk("p2_stallA_valid", stage_valid, 4'b0111);
        chk("p2_stallA_data", stage_data, 64'h0000_0012_0013_0014);
        #1;
        chk("p2_stallB_in_ready", in_ready, 0);
        tick();
        chk("p2_stallB_valid", stage_valid, 4'b0111);
        chk("p2_stallB_data", stage_data, 64'h0000_0012_0013_0014);
        stall_req = '0; in_valid = 1'b0; in_data = '0;
        tick();
        chk("p2_release_valid", stage_valid, 4'b1110);
        chk("p2_release_data", stage_data, 64'h0012_0013_0014_0000);
        tick(); tick(); tick();
        chk("p2_drain_valid", stage_valid, 0);
        chk("p2_retire", retire_count, 4);
        chk("p2_bubble", bubble_count, 6);

        // Bubble collapse behind a blocked oldest stage
        in_valid = 1'b1; in_data = 16'h21;
        tick();
        in_valid = 1'b0; in_data = '0;
        tick(); tick();
        in_valid = 1'b1; in_data = 16'h22;
        tick();
        chk("p3_start_valid", stage_valid, 4'b1001);
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        chk("p3_in_ready1", in_ready, 1);
        tick();
        chk("p3_valid1", stage_valid, 4'b1010);
        chk("p3_data1", stage_data, 64'h0021_0000_0022_0000);
        #1;
        chk("p3_in_ready2", in_ready, 1);
        tick();
        chk("p3_valid2", stage_valid, 4'b1100);
        chk("p3_data2", stage_data, 64'h0021_0022_0000_0000);
        in_valid = 1'b1; in_data = 16'h23;
        #1;
        chk("p3_in_ready3", in_ready, 1);
        tick();
        chk("p3_valid3", stage_valid, 4'b1101);
        chk("p3_data3", stage_data, 64'h0021_0022_0000_0023);
        in_data = 16'h24;
        #1;
        chk("p3_in_ready4", in_ready, 1);
        tick();
        chk("p3_valid4", stage_valid, 4'b1111);
        chk("p3_data4", stage_data, 64'h0021_0022_0023_0024);
        in_valid = 1'b0; in_data = '0;
        #1;
        chk("p3_blocked_in_ready", in_ready, 0);

        // Flush from stage 2 kills stages 0..1 and the 1->2 move
        out_ready = 1'b1; flush_req = 4'b0100; in_valid = 1'b1; in_data = 16'h99;
        #1;
        chk("p4_in_ready", in_ready, 0);
        tick();
        flush_req = '0; in_valid = 1'b0; in_data = '0;
        chk("p4_valid", stage_valid, 4'b1000);
        chk("p4_data", stage_data, 64'h0022_0000_0000_0000);
        chk("p4_out_data", out_data, 16'h22);

        // Kill beats stall
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h31 + i);
            tick();
        end
        chk("p5_fill_valid", stage_valid, 4'hF);
        chk("p5_fill_data", stage_data, 64'h0022_0031_0032_0033);
        stall_req = 4'b0010; flush_req = 4'b1000; in_data = 16'h44;
        #1;
        chk("p5_in_ready", in_ready, 0);
        tick();
        chk("p5_valid", stage_valid, 4'b1000);
        chk("p5_data", stage_data, 64'h0022_0000_0000_0000);

        // Reset mid-stream overrides everything
        stall_req = 4'b0001; flush_req = 4'b0010; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h55; reset = 1'b1;
        #1;
        chk("p6_in_ready", in_ready, 0);
        tick();
        chk("p6_valid", stage_valid, 0);
        chk("p6_data", stage_data, 0);
        chk("p6_retire", retire_count, 0);
        chk("p6_bubble", bubble_count, 0);
        reset = 1'b0; stall_req = '0; flush_req = '0; in_valid = 1'b0; in_data = '0;

        // 4-bit counter wrap, then clear coinciding with a retirement
        for (int c = 1; c <= 21; c++) begin
            in_valid  = (c <= 17);
            in_data   = (c <= 17) ? 16'(16'h40 + c) : 16'h0;
            cnt_clear = (c == 21);
            tick();
            if (c == 4)  chk("p7_first_out", out_data, 16'h41);
            if (c == 19) chk("p7_retire15", retire_count, 15);
            if (c == 20) begin
                chk("p7_retire_wrap", retire_count, 0);
                chk("p7_bubble", bubble_count, 4);
                chk("p7_out_valid", out_valid, 1);
            end
            if (c == 21) begin
                chk("p7_clear_retire", retire_count, 0);
                chk("p7_clear_bubble", bubble_count, 0);
            end
        end
        cnt_clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of pipeline stages, legal range 2..8; stage 0 is youngest and stage STAGES-1 is oldest.
REQ-002 SHALL have parameter WIDTH, default 64, payload width per stage (packed PC + instruction).
REQ-003 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  payload entering stage 0.
REQ-008 SHALL have port in_ready  output  1  stage 0 accepts in_data at the next edge.
REQ-009 SHALL have port stall_req  input  STAGES  bit k: stage k cannot advance this cycle.
REQ-010 SHALL have port flush_req  input  STAGES  bit k: kill every stage younger than k; bit 0 is ignored.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the oldest stage's payload.
REQ-012 SHALL have port stage_valid  output  STAGES  valid bit of each stage.
REQ-013 SHALL have port stage_data  output  STAGES*WIDTH  payload of each stage; stage k occupies bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have port out_valid  output  1  equals stage_valid[STAGES-1].
REQ-015 SHALL have port out_data  output  WIDTH  equals payload of stage STAGES-1.
REQ-016 SHALL have port cnt_clear  input  1  synchronous clear of both counters.
REQ-017 SHALL have port retire_count  output  CNT_W  number of retired payloads.
REQ-018 SHALL have port bubble_count  output  CNT_W  number of cycles with out_valid low.

Function
REQ-019 SHALL compute hold[STAGES-1] = valid[STAGES-1] & (stall_req[STAGES-1] | ~out_ready).
REQ-020 SHALL compute hold[k] = valid[k] & (stall_req[k] | hold[k+1]) for k < STAGES-1; an invalid stage never holds, so bubbles collapse.
REQ-021 SHALL compute kill[k] = OR of flush_req[j] for all j > k.
REQ-022 SHALL update each stage per edge with priority kill > hold > load: kill clears valid and zeroes data; hold keeps contents.
REQ-023 On load, stage k>0 SHALL take stage k-1 contents if valid[k-1] & ~hold[k-1] & ~kill[k-1]; otherwise it SHALL take a bubble (valid 0, data 0).
REQ-024 On load, stage 0 SHALL take in_data with valid 1 when in_valid & in_ready; otherwise it SHALL take a bubble.
REQ-025 SHALL drive in_ready = ~reset & ~hold[0] & ~(OR of flush_req[STAGES-1:1]) combinationally.
REQ-026 Stage k SHALL be unaffected by its own flush_req[k]; only younger stages are killed.
REQ-027 Latency SHALL be exactly STAGES edges from acceptance to out_valid when no hold or kill occurs; throughput SHALL be one payload per cycle.
REQ-028 retire_count SHALL increment by 1 on each edge where out_valid & out_ready, wrapping modulo 2^CNT_W.
REQ-029 bubble_count SHALL increment by 1 on each edge where out_valid is 0, wrapping modulo 2^CNT_W.
REQ-030 cnt_clear SHALL zero both counters, taking priority over increment, and SHALL NOT affect pipeline state.

Reset
REQ-031 While reset is high at an edge, every stage valid SHALL become 0, every stage data SHALL become 0, and both counters SHALL become 0.
REQ-032 Reset SHALL override all of flush, hold, load and counter activity, including mid-stream traffic.
REQ-033 in_ready SHALL be 0 while reset is high.

Verification
REQ-034 Reset, then offer payloads 1..6 back-to-back with out_ready=1 -> out_data shows 1..6 on consecutive cycles, the first 4 edges after its acceptance; retire_count=6.
REQ-035 Full pipeline, stall_req[2]=1 for 2 cycles, out_ready=1 -> stages 0..2 hold, stage 3 retires then shows a bubble, in_ready=0 for both cycles; no payload is lost or duplicated.
REQ-036 Only stage 3 valid with out_ready=0, stage 0 valid, stages 1..2 empty -> stage 0 payload moves up one stage per cycle to stage 2, then holds; in_ready=1 until stage 0 refills and blocks.
REQ-037 All stages valid (A0..A3), flush_req[2]=1 for one cycle -> A3 retires, A2 moves to stage 3, stages 0..2 become invalid, in_ready=0 that cycle.
REQ-038 stall_req[1]=1 and flush_req[3]=1 in the same cycle -> kill wins: stages 0..2 invalid after the edge, stage 3 unaffected.
REQ-039 With CNT_W=4, retire 16 payloads -> retire_count returns to 0; cnt_clear together with a retirement -> retire_count=0.
